// File: rtl/dpwm_comp_dt.sv
// Multi-channel DPWM comparator with double-buffered duty and complementary dead-time gate outputs.
// Optional build macro DPWM_FAULT_EN adds a sticky active-low fault input with a clear request.
module dpwm_comp_dt #(
    parameter int WIDTH = 11,
    parameter int NCH   = 4,
    parameter int DT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NCH*WIDTH-1:0]  ramp,
    input  logic [NCH*WIDTH-1:0]  ramp_s,
    input  logic [NCH-1:0]        shflag,
    input  logic [NCH*WIDTH-1:0]  duty_in,
    input  logic                  duty_load,
    input  logic                  sync,
    input  logic [DT_W-1:0]       dead_time,
`ifdef DPWM_FAULT_EN
    input  logic                  fault_n,
    input  logic                  fault_clr,
`endif
    output logic [NCH-1:0]        pwm_h,
    output logic [NCH-1:0]        pwm_l
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_DT_H = 3'd2,
        ST_HI   = 3'd3,
        ST_DT_L = 3'd4
    } state_t;

    localparam logic [DT_W-1:0] CNT_ZERO = DT_W'(0);
    localparam logic [DT_W-1:0] CNT_ONE  = DT_W'(1);

    logic [WIDTH-1:0] r_shadow   [NCH];
    logic [WIDTH-1:0] r_active   [NCH];
    logic [WIDTH-1:0] w_sel_ramp [NCH];
    logic [NCH-1:0]   r_raw;
    state_t           r_state    [NCH];
    state_t           w_state_nxt[NCH];
    logic [DT_W-1:0]  r_cnt      [NCH];
    logic [DT_W-1:0]  w_cnt_nxt  [NCH];
    logic             w_force_idle;

    // Shadow/active duty buffers; a load coinciding with sync bypasses the shadow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (duty_load) begin
                    r_shadow[i] <= duty_in[i*WIDTH +: WIDTH];
                end
                if (sync) begin
                    r_active[i] <= duty_load ? duty_in[i*WIDTH +: WIDTH] : r_shadow[i];
                end
            end
        end
    end

    // Per-channel carrier selection between the plain and the shifted ramp.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (shflag[i]) begin
                w_sel_ramp[i] = ramp_s[i*WIDTH +: WIDTH];
            end else begin
                w_sel_ramp[i] = ramp[i*WIDTH +: WIDTH];
            end
        end
    end

    // Registered unsigned compare of the active duty against the selected ramp.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_raw <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_raw[i] <= (r_active[i] > w_sel_ramp[i]);
            end
        end
    end

`ifdef DPWM_FAULT_EN
    logic r_fault;

    // Sticky fault flag; an asserted fault dominates a simultaneous clear request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fault <= 1'b0;
        end else if (!fault_n) begin
            r_fault <= 1'b1;
        end else if (fault_clr) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= r_fault;
        end
    end

    assign w_force_idle = (!en) || r_fault;
`else
    assign w_force_idle = !en;
`endif

    // Gate FSM state and dead-time counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Next-state logic; dead_time is captured only on entry to a dead-time state.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (w_force_idle) begin
                w_state_nxt[i] = ST_IDLE;
                w_cnt_nxt[i]   = CNT_ZERO;
            end else begin
                case (r_state[i])
                    ST_IDLE: begin
                        w_cnt_nxt[i]   = dead_time;
                        w_state_nxt[i] = r_raw[i] ? ST_DT_H : ST_DT_L;
                    end
                    ST_LO: begin
                        if (r_raw[i]) begin
                            if (dead_time == CNT_ZERO) begin
                                w_state_nxt[i] = ST_HI;
                            end else begin
                                w_state_nxt[i] = ST_DT_H;
                                w_cnt_nxt[i]   = dead_time;
                            end
                        end else begin
                            w_state_nxt[i] = ST_LO;
                        end
                    end
                    ST_DT_H: begin
                        if (!r_raw[i]) begin
                            w_state_nxt[i] = ST_LO;
                            w_cnt_nxt[i]   = CNT_ZERO;
                        end else if (r_cnt[i] <= CNT_ONE) begin
                            w_state_nxt[i] = ST_HI;
                            w_cnt_nxt[i]   = CNT_ZERO;
                        end else begin
                            w_cnt_nxt[i]   = r_cnt[i] - CNT_ONE;
                        end
                    end
                    ST_HI: begin
                        if (!r_raw[i]) begin
                            if (dead_time == CNT_ZERO) begin
                                w_state_nxt[i] = ST_LO;
                            end else begin
                                w_state_nxt[i] = ST_DT_L;
                                w_cnt_nxt[i]   = dead_time;
                            end
                        end else begin
                            w_state_nxt[i] = ST_HI;
                        end
                    end
                    ST_DT_L: begin
                        if (r_raw[i]) begin
                            w_state_nxt[i] = ST_HI;
                            w_cnt_nxt[i]   = CNT_ZERO;
                        end else if (r_cnt[i] <= CNT_ONE) begin
                            w_state_nxt[i] = ST_LO;
                            w_cnt_nxt[i]   = CNT_ZERO;
                        end else begin
                            w_cnt_nxt[i]   = r_cnt[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_IDLE;
                        w_cnt_nxt[i]   = CNT_ZERO;
                    end
                endcase
            end
        end
    end

    // Gate decode straight from the state register, so the pair is mutually exclusive by construction.
    always_comb begin
        pwm_h = '0;
        pwm_l = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_h[i] = (r_state[i] == ST_HI);
            pwm_l[i] = (r_state[i] == ST_LO);
        end
    end

endmodule

// File: tb/tb_dpwm_comp_dt.sv
// Scoreboard bench for dpwm_comp_dt: directed sweeps push expected gate states per cycle, a monitor compares.
module tb_dpwm_comp_dt;
    localparam int WIDTH = 11;
    localparam int NCH   = 4;
    localparam int DT_W  = 6;
    localparam logic [3:0] ALL  = 4'hF;
    localparam logic [3:0] NONE = 4'h0;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [NCH*WIDTH-1:0] ramp;
    logic [NCH*WIDTH-1:0] ramp_s;
    logic [NCH-1:0]       shflag;
    logic [NCH*WIDTH-1:0] duty_in;
    logic                 duty_load;
    logic                 sync;
    logic [DT_W-1:0]      dead_time;
    logic [NCH-1:0]       pwm_h;
    logic [NCH-1:0]       pwm_l;
`ifdef DPWM_FAULT_EN
    logic                 fault_n;
    logic                 fault_clr;
`endif

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int         cyc;
        logic [3:0] h;
        logic [3:0] l;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    dpwm_comp_dt #(.WIDTH(WIDTH), .NCH(NCH), .DT_W(DT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ramp      (ramp),
        .ramp_s    (ramp_s),
        .shflag    (shflag),
        .duty_in   (duty_in),
        .duty_load (duty_load),
        .sync      (sync),
        .dead_time (dead_time),
`ifdef DPWM_FAULT_EN
        .fault_n   (fault_n),
        .fault_clr (fault_clr),
`endif
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input string nm, input int c, input logic [3:0] h, input logic [3:0] l);
        exp_t e;
        e.cyc = c;
        e.h   = h;
        e.l   = l;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        duty_load = 1'b0;
        sync      = 1'b0;
`ifdef DPWM_FAULT_EN
        fault_clr = 1'b0;
`endif
    endtask

    task automatic set_ramp(input int r);
        for (int i = 0; i < NCH; i++) begin
            ramp[i*WIDTH +: WIDTH]   = WIDTH'(r);
            ramp_s[i*WIDTH +: WIDTH] = WIDTH'((r + 1024) % 2048);
        end
    endtask

    task automatic ramp_to(input int from, input int to);
        for (int r = from; r <= to; r++) begin
            step();
            set_ramp(r);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic load_all(input int v, input logic s);
        for (int i = 0; i < NCH; i++) duty_in[i*WIDTH +: WIDTH] = WIDTH'(v);
        duty_load = 1'b1;
        sync      = s;
    endtask

    // Monitor: pops every expectation due at this cycle and compares against the gate outputs.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if (e.cyc != cyc || pwm_h !== e.h || pwm_l !== e.l) begin
                    n_miss++;
                    $display("FAIL %s cyc=%0d (due %0d): got h=%b l=%b, want h=%b l=%b",
                             nm, cyc, e.cyc, pwm_h, pwm_l, e.h, e.l);
                end
            end
        end
    end

    initial begin
        int k0;
        int guard;
        rst       = 1'b0;
        en        = 1'b0;
        shflag    = '0;
        duty_in   = '0;
        duty_load = 1'b0;
        sync      = 1'b0;
        dead_time = '0;
        set_ramp(2047);
`ifdef DPWM_FAULT_EN
        fault_n   = 1'b1;
        fault_clr = 1'b0;
`endif
        step();
        expect_at("reset", cyc + 1, NONE, NONE);
        hold(2);
        rst = 1'b1;
        en  = 1'b1;
        load_all(1024, 1'b0);
        step();
        sync = 1'b1;
        hold(6);

        // Test 1: dead_time 0, duty 1024.
        k0 = cyc + 1;
        expect_at("t1_pre",      k0 + 1,    NONE, ALL);
        expect_at("t1_rise",     k0 + 2,    ALL,  NONE);
        expect_at("t1_mid",      k0 + 500,  ALL,  NONE);
        expect_at("t1_last_hi",  k0 + 1025, ALL,  NONE);
        expect_at("t1_fall",     k0 + 1026, NONE, ALL);
        expect_at("t1_late",     k0 + 2000, NONE, ALL);
        ramp_to(0, 2047);

        // Test 2: dead_time 5, with a mid-count dead_time change that must not matter.
        dead_time = 6'd5;
        k0 = cyc + 1;
        expect_at("t2_pre",      k0 + 1,    NONE, ALL);
        expect_at("t2_dth_first",k0 + 2,    NONE, NONE);
        expect_at("t2_dth_last", k0 + 6,    NONE, NONE);
        expect_at("t2_hi",       k0 + 7,    ALL,  NONE);
        expect_at("t2_hi_last",  k0 + 1025, ALL,  NONE);
        expect_at("t2_dtl_first",k0 + 1026, NONE, NONE);
        expect_at("t2_dtl_last", k0 + 1030, NONE, NONE);
        expect_at("t2_lo",       k0 + 1031, NONE, ALL);
        ramp_to(0, 3);
        dead_time = 6'd1;
        ramp_to(4, 9);
        dead_time = 6'd5;
        ramp_to(10, 2047);

        // Test 3: shadow load without sync is invisible; load with sync bypasses.
        dead_time = 6'd0;
        k0 = cyc + 1;
        expect_at("t3_noload",   k0 + 600,  ALL,  NONE);
        expect_at("t3_hi_last",  k0 + 1025, ALL,  NONE);
        expect_at("t3_fall",     k0 + 1026, NONE, ALL);
        ramp_to(0, 99);
        load_all(512, 1'b0);
        ramp_to(100, 2047);
        load_all(300, 1'b1);
        k0 = cyc + 1;
        expect_at("t3b_pre",     k0 + 1,    NONE, ALL);
        expect_at("t3b_rise",    k0 + 2,    ALL,  NONE);
        expect_at("t3b_hi_last", k0 + 301,  ALL,  NONE);
        expect_at("t3b_fall",    k0 + 302,  NONE, ALL);
        ramp_to(0, 2047);

        // Boundary: full-scale duty low only at ramp max; zero duty never high.
        load_all(2047, 1'b1);
        k0 = cyc + 1;
        expect_at("max_rise",    k0 + 2,    ALL,  NONE);
        expect_at("max_hi_last", k0 + 2048, ALL,  NONE);
        expect_at("max_lo",      k0 + 2049, NONE, ALL);
        ramp_to(0, 2047);
        load_all(0, 1'b1);
        k0 = cyc + 1;
        expect_at("zero_start",  k0 + 2,    NONE, ALL);
        expect_at("zero_mid",    k0 + 1000, NONE, ALL);
        expect_at("zero_end",    k0 + 2047, NONE, ALL);
        ramp_to(0, 2047);

        // Test 4: channel 2 follows the shifted ramp.
        load_all(1024, 1'b1);
        shflag = 4'b0100;
        k0 = cyc + 1;
        expect_at("t4_first",    k0 + 2,    4'b1011, 4'b0100);
        expect_at("t4_half",     k0 + 1025, 4'b1011, 4'b0100);
        expect_at("t4_swap",     k0 + 1026, 4'b0100, 4'b1011);
        expect_at("t4_end",      k0 + 2047, 4'b0100, 4'b1011);
        ramp_to(0, 2047);
        shflag = 4'b0000;
        hold(4);

        // Test 5: a 3-cycle raw pulse aborts inside the 5-cycle dead time.
        dead_time = 6'd5;
        k0 = cyc + 1;
        expect_at("t5_pre",      k0 + 1,    NONE, ALL);
        expect_at("t5_dt_a",     k0 + 2,    NONE, NONE);
        expect_at("t5_dt_b",     k0 + 3,    NONE, NONE);
        expect_at("t5_dt_c",     k0 + 4,    NONE, NONE);
        expect_at("t5_abort_lo", k0 + 5,    NONE, ALL);
        expect_at("t5_stay_lo",  k0 + 8,    NONE, ALL);
        repeat (3) begin
            step();
            set_ramp(0);
        end
        step();
        set_ramp(2047);
        hold(8);

        // Test 6: reset while HI, recovery through dead-time, then disable.
        dead_time = 6'd0;
        k0 = cyc + 1;
        expect_at("t6_hi",       k0 + 2,    ALL,  NONE);
        expect_at("t6_hi_hold",  k0 + 4,    ALL,  NONE);
        expect_at("t6_reset",    k0 + 5,    NONE, NONE);
        expect_at("t6_dtl",      k0 + 6,    NONE, NONE);
        expect_at("t6_lo",       k0 + 7,    NONE, ALL);
        expect_at("t6_hi_again", k0 + 8,    ALL,  NONE);
        expect_at("t6_en_off",   k0 + 9,    NONE, NONE);
        expect_at("t6_idle",     k0 + 10,   NONE, NONE);
        repeat (4) begin
            step();
            set_ramp(0);
        end
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        load_all(1024, 1'b1);
        hold(3);
        en = 1'b0;
        hold(3);

`ifdef DPWM_FAULT_EN
        // Fault: one-cycle shutdown latency, sticky until clear with fault_n high.
        en = 1'b1;
        hold(4);
        k0 = cyc + 1;
        expect_at("f_before",    k0 + 1,    ALL,  NONE);
        expect_at("f_shutdown",  k0 + 2,    NONE, NONE);
        expect_at("f_sticky",    k0 + 5,    NONE, NONE);
        expect_at("f_clr_edge",  k0 + 7,    NONE, NONE);
        expect_at("f_dth",       k0 + 8,    NONE, NONE);
        expect_at("f_resume",    k0 + 9,    ALL,  NONE);
        step();
        fault_n = 1'b0;
        step();
        fault_n = 1'b1;
        hold(4);
        step();
        fault_clr = 1'b1;
        hold(4);
`endif

        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            step();
            guard++;
        end
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations never reached, want 0", exp_q.size());
            n_miss += exp_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dpwm_comp_dt.md
Name: dpwm_comp_dt

Overview:
Multi-channel DPWM comparator for the FCML modulator, with per-channel ramp/shifted-ramp selection and double-buffered duty registers. Active duty updates only on a carrier sync pulse. Each channel drives a complementary high/low gate pair with programmable dead time. It sits between the ramp/phase-shift generator and the gate-driver outputs, one channel per switching cell.

Parameters:
WIDTH, 11, bit width of ramps and duty words
NCH, 4, number of channels (switching cells)
DT_W, 6, bit width of the dead-time count

Ports:
clk  in  1  reference clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
en  in  1  modulator enable
ramp  in  NCH*WIDTH  per-channel reference ramp, channel i at bits [i*WIDTH +: WIDTH]
ramp_s  in  NCH*WIDTH  per-channel shifted reference ramp, same packing
shflag  in  NCH  per-channel select: 0 selects ramp, 1 selects ramp_s
duty_in  in  NCH*WIDTH  new duty words, same packing
duty_load  in  1  write duty_in into the shadow registers
sync  in  1  carrier-period boundary pulse; copies shadow to active
dead_time  in  DT_W  dead time in clk cycles, shared by all channels
pwm_h  out  NCH  high-side gate, per channel
pwm_l  out  NCH  low-side gate, per channel

Behaviour:
- Reset (rst=0 at a rising edge): shadow=0, active=0, raw=0, all FSMs go to IDLE, counters=0, pwm_h=0, pwm_l=0. Reset mid-dead-time aborts the count.
- Shadow: duty_load=1 -> shadow <= duty_in. sync=1 -> active <= shadow. If duty_load and sync occur in the same cycle, active <= duty_in (bypass).
- Compare: raw[i] <= (active[i] > sel_ramp[i]), unsigned. sel_ramp is ramp_s when shflag[i]=1, else ramp. Latency is 1 cycle. duty=0 gives raw always 0. duty=2^WIDTH-1 gives raw=0 only when the ramp is at its maximum.
- Per-channel FSM states: IDLE, LO, DT_H, HI, DT_L. Outputs decode from the state register: pwm_h=1 only in HI; pwm_l=1 only in LO. The two outputs are never both 1.
- IDLE: entered whenever en=0, from any state; both outputs are 0. When en=1 it goes to DT_H if raw=1, else DT_L, loading cnt=dead_time.
- LO with raw=1: if dead_time=0, go to HI; else go to DT_H with cnt=dead_time.
- DT_H:
  - If raw=0, return to LO immediately (pulse abort).
  - Else if cnt<=1, go to HI.
  - Else cnt decrements.
- HI and DT_L mirror LO and DT_H with the polarities swapped.
- Both-off interval is exactly dead_time cycles per transition.
- Total latency from ramp crossing to output edge is 2 cycles with dead_time=0, else 2+dead_time cycles.
- dead_time is sampled only when a DT state is entered; changing it mid-count does not affect the count in progress.
- Counters are DT_W bits wide and never wrap.

Optional Feature:
DPWM_FAULT_EN adds two ports:
- fault_n: in, 1 bit, active-low fault.
- fault_clr: in, 1 bit, clear request.

With the macro:
- fault_n=0 at a rising edge sets a sticky fault flag. On the next edge all FSMs go to IDLE and pwm_h=pwm_l=0 (1-cycle shutdown latency).
- The flag clears only when fault_clr=1 and fault_n=1 in the same cycle. Operation then resumes through the DT states.
- Reset clears the flag.

Without the macro: neither port exists and there is no fault logic.

Test Plan:
1. dead_time=0; duty 1024 loaded and synced on all channels; ramp swept 0..2047 once per period -> pwm_h high for ramp 0..1023 (1024 cycles) with 2-cycle latency; pwm_l is the exact complement.
2. dead_time=5, duty 1024 -> each edge has exactly 5 cycles with pwm_h=pwm_l=0; pwm_h width = 1024-5.
3. duty_load of 512 mid-period with no sync -> output unchanged until the next sync. Then simultaneous duty_load=300 and sync -> 300 takes effect immediately.
4. shflag[2]=1 with ramp_s offset by 1024 -> channel 2 pulse shifted 1024 cycles; other channels unaffected.
5. dead_time=5, raw high for only 3 cycles -> pwm_h never asserts; pwm_l returns high after the abort.
6. rst=0 for one cycle during HI, then en=0 -> both outputs 0 the next edge. With DPWM_FAULT_EN: fault_n low -> shutdown in 1 cycle, and it holds until fault_clr.
